// File: rtl/spell_mem_initiator.sv
// Spell memory port initiator: single-beat core requests driven as a select/addr/write
// handshake toward a responder, with data_ready return-to-zero. Option: SPELL_MEM_TIMEOUT_EN.
module spell_mem_initiator #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_data_type,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_error,
  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic       mem_write,
  output logic       mem_type_data,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_data_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t     state, state_d;
  logic       sel_d, wr_d, type_d, rv_d, err_d;
  logic [7:0] addr_d, wdata_d, rdata_d;

`ifdef SPELL_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt, cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  assign req_ready = (state == IDLE) && !rst;

  always_comb begin
    state_d = state;
    sel_d   = mem_select;
    wr_d    = mem_write;
    type_d  = mem_type_data;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    rdata_d = resp_rdata;
    rv_d    = 1'b0;
    err_d   = resp_error;
`ifdef SPELL_MEM_TIMEOUT_EN
    cnt_d   = cnt;
`endif
    case (state)
      IDLE: begin
        sel_d = 1'b0;
        if (req_valid) begin
          sel_d   = 1'b1;
          wr_d    = req_write;
          type_d  = req_data_type;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ACCESS;
`ifdef SPELL_MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ACCESS: begin
        // data_ready takes priority over an expiring timeout in the same cycle
        if (mem_data_ready) begin
          sel_d   = 1'b0;
          wr_d    = 1'b0;
          rv_d    = 1'b1;
          err_d   = 1'b0;
          if (!mem_write) rdata_d = mem_rdata;
          state_d = RELEASE;
        end
`ifdef SPELL_MEM_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          sel_d   = 1'b0;
          wr_d    = 1'b0;
          rv_d    = 1'b1;
          err_d   = 1'b1;
          rdata_d = 8'h00;
          cnt_d   = cnt + CNT_W'(1);
          state_d = RELEASE;
        end else begin
          cnt_d   = cnt + CNT_W'(1);
        end
`endif
      end
      RELEASE: begin
        // hold off the next access until the responder has dropped data_ready
        if (!mem_data_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mem_select    <= 1'b0;
      mem_write     <= 1'b0;
      mem_type_data <= 1'b0;
      mem_addr      <= 8'h00;
      mem_wdata     <= 8'h00;
      resp_valid    <= 1'b0;
      resp_rdata    <= 8'h00;
      resp_error    <= 1'b0;
`ifdef SPELL_MEM_TIMEOUT_EN
      cnt           <= '0;
`endif
    end else begin
      state         <= state_d;
      mem_select    <= sel_d;
      mem_write     <= wr_d;
      mem_type_data <= type_d;
      mem_addr      <= addr_d;
      mem_wdata     <= wdata_d;
      resp_valid    <= rv_d;
      resp_rdata    <= rdata_d;
      resp_error    <= err_d;
`ifdef SPELL_MEM_TIMEOUT_EN
      cnt           <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_spell_mem_initiator.sv
// Bench for spell_mem_initiator: responder model with programmable wait states, a
// transaction-level expectation model checked every cycle, and directed literal checks.
module tb_spell_mem_initiator;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_write = 1'b0, req_data_type = 1'b0;
  logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
  logic       req_ready, resp_valid, resp_error;
  logic       mem_select, mem_write, mem_type_data;
  logic [7:0] resp_rdata, mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_data_ready = 1'b0;

  spell_mem_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_data_type(req_data_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_select(mem_select), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_type_data(mem_type_data), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_ready(mem_data_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Responder: data_ready rises wait_cycles edges after it first sees select, falls when select drops
  int         wait_cycles = 0;
  int         wcnt = 0;
  logic [7:0] mem_arr [2][256];
  always @(posedge clk) begin
    if (!mem_select) begin
      wcnt           <= 0;
      mem_data_ready <= 1'b0;
    end else if (wcnt >= wait_cycles) begin
      mem_data_ready <= 1'b1;
      if (mem_write) mem_arr[mem_type_data][mem_addr] <= mem_wdata;
      else           mem_rdata <= mem_arr[mem_type_data][mem_addr];
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  // Transaction model: one outstanding access, timings derived from the responder wait count
  logic       m_pend = 1'b0, m_rst_pend = 1'b1;
  int         m_acc = 0, m_resp = 0, m_free = 0;
  logic       m_wr = 1'b0, m_type = 1'b0, m_to = 1'b0;
  logic [7:0] m_addr = 8'h00, m_wdata = 8'h00, m_rd = 8'h00;
  logic [7:0] m_hold_rdata = 8'h00;
  logic       m_hold_err = 1'b0;
  logic [7:0] shadow [2][256];

  int         obs_acc = 0, last_lat = 0, last_free = 0, sel_cnt = 0, resp_cnt = 0;
  logic       obs_busy = 1'b0, last_err = 1'b0;
  logic [7:0] last_rdata = 8'h00;
  int         acc_q[$];

  initial begin
    logic idle_e, sel_e, rv_e;
    int   w;
    forever begin
      @(negedge clk);
      if (m_rst_pend) begin
        m_pend = 1'b0; m_hold_rdata = 8'h00; m_hold_err = 1'b0; obs_busy = 1'b0;
      end
      idle_e = !m_pend || (cyc >= m_free);
      sel_e  = m_pend && (cyc >= m_acc) && (cyc < m_resp);
      rv_e   = m_pend && (cyc == m_resp);
      if (rv_e) begin
        if (m_to)       m_hold_rdata = 8'h00;
        else if (!m_wr) m_hold_rdata = m_rd;
        m_hold_err = m_to;
      end
      check("req_ready", req_ready, idle_e && !rst);
      check("mem_select", mem_select, sel_e);
      check("mem_write", mem_write, sel_e && m_wr);
      if (sel_e) begin
        check("mem_addr", mem_addr, m_addr);
        check("mem_type_data", mem_type_data, m_type);
        if (m_wr) check("mem_wdata", mem_wdata, m_wdata);
      end
      check("resp_valid", resp_valid, rv_e);
      check("resp_rdata", resp_rdata, m_hold_rdata);
      check("resp_error", resp_error, m_hold_err);

      if (mem_select) sel_cnt++;
      if (resp_valid) begin
        resp_cnt++;
        last_lat   = cyc - obs_acc;
        last_rdata = resp_rdata;
        last_err   = resp_error;
      end
      if (obs_busy && req_ready) begin
        last_free = cyc - obs_acc;
        obs_busy  = 1'b0;
      end
      if (req_valid && req_ready) begin
        obs_acc = cyc + 1; obs_busy = 1'b1; sel_cnt = 0; acc_q.push_back(cyc + 1);
      end

      m_rst_pend = rst;
      if (req_valid && idle_e && !rst) begin
        w       = wait_cycles;
        m_pend  = 1'b1;
        m_acc   = cyc + 1;
        m_wr    = req_write;
        m_type  = req_data_type;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        m_resp  = m_acc + 2 + w;
        m_to    = 1'b0;
`ifdef SPELL_MEM_TIMEOUT_EN
        if (w + 2 > TO) begin
          m_resp = m_acc + TO;
          m_to   = 1'b1;
        end
`endif
        m_free = (m_acc + 1 + w <= m_resp) ? m_resp + 2 : m_resp + 1;
        m_rd   = shadow[m_type][m_addr];
        if (m_wr && !m_to) shadow[m_type][m_addr] = m_wdata;
      end
    end
  end

  // Call #1 after a rising edge; returns #1 after the accepting edge
  task automatic start_req(input logic wr, input logic typ, input logic [7:0] addr,
                           input logic [7:0] wd, input logic keep);
    int n;
    req_valid = 1'b1; req_write = wr; req_data_type = typ; req_addr = addr; req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("accept_bound", req_ready, 1'b1);
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_bound", req_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_select", mem_select, 1'b0);
    check("rst_addr", mem_addr, 8'h00);
    check("rst_rdata", resp_rdata, 8'h00);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_ready", req_ready, 1'b1);
    @(posedge clk); #1;

    // zero-wait code write
    wait_cycles = 0;
    start_req(1'b1, 1'b0, 8'h05, 8'hA5, 1'b0); wait_idle();
    check("wr_lat", last_lat, 2);
    check("wr_free", last_free, 4);
    check("wr_sel_cycles", sel_cnt, 2);
    check("wr_err", last_err, 1'b0);
    check("wr_mem", mem_arr[0][8'h05], 8'hA5);
    check("resp_count1", resp_cnt, 1);

    // data write then reads
    start_req(1'b1, 1'b1, 8'h03, 8'h3C, 1'b0); wait_idle();
    start_req(1'b0, 1'b1, 8'h03, 8'h00, 1'b0); wait_idle();
    check("rd_data03", last_rdata, 8'h3C);
    start_req(1'b0, 1'b0, 8'h05, 8'h00, 1'b0); wait_idle();
    check("rd_code05", last_rdata, 8'hA5);
    start_req(1'b1, 1'b1, 8'h50, 8'h77, 1'b0); wait_idle();
    check("wr_keeps_rdata", resp_rdata, 8'hA5);
    check("resp_count2", resp_cnt, 5);

    // 3 wait states, back-to-back requests with req_valid held
    wait_cycles = 3;
    start_req(1'b1, 1'b1, 8'h41, 8'h5A, 1'b1);
    start_req(1'b0, 1'b1, 8'h03, 8'h00, 1'b0);
    wait_idle();
    check("b2b_rdata", last_rdata, 8'h3C);
    check("b2b_lat", last_lat, 5);
    check("b2b_gap", acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2], 8);
    check("resp_count3", resp_cnt, 7);

    // reset while in ACCESS
    wait_cycles = 5;
    start_req(1'b0, 1'b1, 8'h41, 8'h00, 1'b0);
    @(negedge clk);
    check("pre_rst_select", mem_select, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_select", mem_select, 1'b0);
    check("post_rst_resp_valid", resp_valid, 1'b0);
    check("post_rst_rdata", resp_rdata, 8'h00);
    check("post_rst_ready", req_ready, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check("rst_no_resp", resp_cnt, 7);

    wait_cycles = 0;
    start_req(1'b0, 1'b1, 8'h41, 8'h00, 1'b0); wait_idle();
    check("rd_data41", last_rdata, 8'h5A);

`ifdef SPELL_MEM_TIMEOUT_EN
    wait_cycles = 1000;
    start_req(1'b0, 1'b1, 8'h10, 8'h00, 1'b0); wait_idle();
    check("to_err", last_err, 1'b1);
    check("to_rdata", last_rdata, 8'h00);
    check("to_lat", last_lat, TO);
    check("to_free", last_free, TO + 1);
    wait_cycles = 2;
    start_req(1'b0, 1'b1, 8'h50, 8'h00, 1'b0); wait_idle();
    check("edge_err", last_err, 1'b0);
    check("edge_rdata", last_rdata, 8'h77);
    check("edge_lat", last_lat, 4);
    wait_cycles = 3;
    start_req(1'b0, 1'b1, 8'h41, 8'h00, 1'b0); wait_idle();
    check("late_err", last_err, 1'b1);
    check("late_rdata", last_rdata, 8'h00);
    check("late_free", last_free, 6);
    check("resp_count4", resp_cnt, 11);
`else
    wait_cycles = 100;
    start_req(1'b0, 1'b1, 8'h50, 8'h00, 1'b0); wait_idle();
    check("stall_rdata", last_rdata, 8'h77);
    check("stall_err", last_err, 1'b0);
    check("stall_lat", last_lat, 102);
    check("resp_count4", resp_cnt, 9);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spell_mem_initiator.md
Name: spell_mem_initiator

Overview:
Initiator (master) side of the Spell memory port. It accepts single-beat code/data read and write requests from the core over a valid/ready interface. It drives the select/addr/write/data handshake toward a memory responder and waits for data_ready. It returns one response pulse per request and enforces return-to-zero of data_ready before the next access. It sits between the Spell execution core and the internal or external memory block.

Parameters:
TIMEOUT_CYCLES, 15, ACCESS-state cycles without mem_data_ready before abort; used only with SPELL_MEM_TIMEOUT_EN; legal range 1..255.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  core request valid
req_ready  output  1  initiator can accept a request
req_write  input  1  1 = write, 0 = read
req_data_type  input  1  1 = data memory, 0 = code memory
req_addr  input  8  access address
req_wdata  input  8  write data
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  8  read data, valid with resp_valid on reads
resp_error  output  1  access aborted by timeout, valid with resp_valid
mem_select  output  1  memory select
mem_addr  output  8  memory address
mem_write  output  1  memory write strobe
mem_type_data  output  1  memory type, 1 = data
mem_wdata  output  8  data to memory data_in
mem_rdata  input  8  data from memory data_out
mem_data_ready  input  1  memory access complete

Behaviour:
- Single clock clk; reset rst is synchronous, active-high. All outputs registered except req_ready = (state==IDLE) && !rst.
- Reset values: mem_select 0, mem_write 0, mem_type_data 0, mem_addr 8'h00, mem_wdata 8'h00, resp_valid 0, resp_rdata 8'h00, resp_error 0, state IDLE, timeout counter 0.
- FSM states: IDLE, ACCESS, RELEASE.
- IDLE: on req_valid && req_ready, latch req_write/req_data_type/req_addr/req_wdata into mem_write/mem_type_data/mem_addr/mem_wdata, set mem_select=1, go to ACCESS. Without req_valid, stay in IDLE with mem_select=0.
- ACCESS: mem_* held stable. When mem_data_ready==1 is sampled:
  - mem_select<=0, mem_write<=0, resp_valid<=1 for exactly one cycle, go to RELEASE.
  - On a read, resp_rdata<=mem_rdata. On a write, resp_rdata is unchanged. resp_error<=0.
- RELEASE: mem_select stays 0. Go to IDLE only when mem_data_ready==0 is sampled, which enforces return-to-zero. mem_addr, mem_type_data and mem_wdata hold their last values.
- Latency with a zero-wait responder (data_ready registered one edge after select):
  - request accepted at edge N;
  - resp_valid high after edge N+2;
  - req_ready high again after edge N+4;
  - maximum throughput is one access per 4 cycles.
- The responder may perform the access a second time on the edge where select falls. Reads and writes are idempotent, so this is acceptable. The initiator issues no other access until data_ready is observed low.
- mem_data_ready seen high while in IDLE (stale from a previous owner): the request is still accepted, but ACCESS may complete immediately. The core must not issue requests until req_ready. The bench never drives data_ready high in IDLE except in the reset test.
- Reset mid-operation (any state): next edge returns to IDLE with reset values. mem_select drops, no resp_valid is produced for the aborted access, and resp_rdata clears to 8'h00.
- resp_valid and resp_error change only at an ACCESS exit. resp_error is 0 for every completed access.

Optional Feature:
SPELL_MEM_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with mem_data_ready==0.
  - When the counter reaches TIMEOUT_CYCLES: mem_select<=0, mem_write<=0, resp_valid<=1, resp_error<=1, resp_rdata<=8'h00, go to RELEASE.
  - mem_data_ready and timeout in the same cycle: data_ready wins, normal completion with resp_error=0.
- Undefined: no counter. ACCESS waits indefinitely and resp_error is constant 0.

Test Plan:
- Write code addr 8'h05 data 8'hA5 to a zero-wait responder model -> mem_select high 2 cycles, mem_write=1, mem_type_data=0, resp_valid pulse at N+2, resp_error=0, req_ready back at N+4.
- Read data addr 8'h03 after writing 8'h3C there -> resp_valid pulse with resp_rdata=8'h3C. A following code read of 8'h05 returns 8'hA5.
- Responder with 3 wait cycles, back-to-back req_valid held high -> second request not accepted until data_ready observed 0; exactly one resp_valid per request; mem_addr stable throughout each ACCESS.
- rst asserted in ACCESS with mem_select=1 -> next edge: mem_select=0, resp_valid=0, resp_rdata=8'h00, state IDLE, req_ready=1 once rst drops.
- With SPELL_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, responder never asserts data_ready:
  - read of 8'h10 -> resp_valid with resp_error=1 and resp_rdata=8'h00 after 4 ACCESS cycles, mem_select low, then IDLE.
  - repeat with data_ready asserted on cycle 4 -> resp_error=0.
- Without the macro, responder stalls 100 cycles and then responds with 8'h77 -> a single resp_valid with resp_rdata=8'h77 and resp_error=0.
